// File: rtl/avalon_mm_regfile.sv
// Avalon-MM register file in front of a start/done compute core: RW operand words,
// RO result words captured on completion, and CTRL/STATUS with a bounded BUSY phase.
module avalon_mm_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RW   = 8,
  parameter int NUM_RO   = 4,
  parameter int TIMEOUT  = 1024,
  parameter int EXP_HI   = 4,
  parameter int EXP_LO   = 7
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 AVL_CS,
  input  logic                 AVL_READ,
  input  logic                 AVL_WRITE,
  input  logic [3:0]           AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]    AVL_ADDR,
  input  logic [31:0]          AVL_WRITEDATA,
  output logic [31:0]          AVL_READDATA,
  output logic                 AVL_READDATAVALID,
  output logic [NUM_RW*32-1:0] CORE_OPERANDS,
  output logic                 CORE_START,
  input  logic                 CORE_DONE,
  input  logic [NUM_RO*32-1:0] CORE_RESULT,
  output logic [31:0]          EXPORT_DATA,
  output logic [1:0]           DBG_STATE
);

  localparam int CTRL_ADDR = NUM_REGS - 2;
  localparam int STAT_ADDR = NUM_REGS - 1;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_st_done;
  logic             r_st_ovr;
  logic             r_st_wrl;
  logic             r_st_to;
  logic [31:0]      r_rw [NUM_RW];
  logic [31:0]      r_ro [NUM_RO];
  logic [31:0]      r_rdata;
  logic             r_rvalid;

  logic             w_wr;
  logic             w_rd;
  logic             w_wr_rw;
  logic             w_wr_rw_ok;
  logic             w_wr_stat;
  logic             w_start_req;
  logic             w_clr_done;
  logic             w_clr_ovr;
  logic             w_clr_wrl;
  logic             w_clr_to;
  logic             w_capture;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      w_bemask;
  logic [31:0]      w_status;
  logic [31:0]      w_words [NUM_REGS];

  assign w_wr        = AVL_CS & AVL_WRITE;
  assign w_rd        = AVL_CS & AVL_READ;
  assign w_wr_rw     = w_wr && (AVL_ADDR < ADDR_W'(NUM_RW));
  assign w_wr_rw_ok  = w_wr_rw && (r_state != S_BUSY);
  assign w_wr_stat   = w_wr && (AVL_ADDR == ADDR_W'(STAT_ADDR));
  assign w_start_req = w_wr && (AVL_ADDR == ADDR_W'(CTRL_ADDR)) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w_clr_done  = w_wr_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w_clr_ovr   = w_wr_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[2];
  assign w_clr_wrl   = w_wr_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[3];
  assign w_clr_to    = w_wr_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[4];
  assign w_capture   = (r_state == S_BUSY) && CORE_DONE;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // CORE_DONE on the expiry cycle wins, so the timeout only fires without it.
  assign w_timeout   = (TIMEOUT != 0) && !CORE_DONE && (w_cnt_inc == CNT_W'(TIMEOUT));
  assign w_bemask    = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}}, {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
  assign w_status    = {27'd0, r_st_to, r_st_wrl, r_st_ovr, (r_state == S_BUSY), r_st_done};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_words
    if (g < NUM_RW) begin : g_rw
      assign w_words[g] = r_rw[g];
    end else if (g < NUM_RW + NUM_RO) begin : g_ro
      assign w_words[g] = r_ro[g - NUM_RW];
    end else if (g == STAT_ADDR) begin : g_stat
      assign w_words[g] = w_status;
    end else begin : g_zero
      assign w_words[g] = '0;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ops
    assign CORE_OPERANDS[(NUM_RW-1-g)*32 +: 32] = r_rw[g];
  end

  assign EXPORT_DATA       = {w_words[EXP_HI][31:16], w_words[EXP_LO][15:0]};
  assign CORE_START        = r_start;
  assign AVL_READDATA      = r_rdata;
  assign AVL_READDATAVALID = r_rvalid;
  assign DBG_STATE         = r_state;

  // Clears are applied first so that a same-cycle set (DONE capture, lock, overrun) wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_st_done <= 1'b0;
      r_st_ovr  <= 1'b0;
      r_st_wrl  <= 1'b0;
      r_st_to   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_clr_done) r_st_done <= 1'b0;
      if (w_clr_ovr)  r_st_ovr  <= 1'b0;
      if (w_clr_wrl)  r_st_wrl  <= 1'b0;
      if (w_clr_to)   r_st_to   <= 1'b0;
      if (w_wr_rw && (r_state == S_BUSY)) r_st_wrl <= 1'b1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_req) begin
            r_state   <= S_BUSY;
            r_start   <= 1'b1;
            r_st_done <= 1'b0;
            r_cnt     <= '0;
          end else if ((r_state == S_DONE) && w_clr_done) begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (w_start_req) r_st_ovr <= 1'b1;
          if (CORE_DONE) begin
            r_st_done <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            r_st_to <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reads have a fixed one-cycle latency: READDATAVALID marks the single cycle in
  // which READDATA carries the word addressed at the previous edge; otherwise both are 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_RW; i++) r_rw[i] <= '0;
      for (int j = 0; j < NUM_RO; j++) r_ro[j] <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (w_wr_rw_ok && (AVL_ADDR == ADDR_W'(i))) begin
          r_rw[i] <= (r_rw[i] & ~w_bemask) | (AVL_WRITEDATA & w_bemask);
        end
      end
      if (w_capture) begin
        for (int j = 0; j < NUM_RO; j++) r_ro[j] <= CORE_RESULT[(NUM_RO-1-j)*32 +: 32];
      end
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_words[AVL_ADDR] : '0;
    end
  end

endmodule

// File: doc/avalon_mm_regfile.md
AVALON_MM_REGFILE -- requirements
Module: avalon_mm_regfile

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_REGS, 16, total 32-bit words; power of 2, at least 8.
- ADDR_W, log2(NUM_REGS), word address width.
- NUM_RW, 8, host read/write operand words at addresses 0..NUM_RW-1.
- NUM_RO, 4, read-only result words at addresses NUM_RW..NUM_RW+NUM_RO-1.
- TIMEOUT, 1024, maximum BUSY cycles; 0 disables the timeout.
- EXP_HI, 4, word driving EXPORT_DATA[31:16].
- EXP_LO, 7, word driving EXPORT_DATA[15:0].
REQ-002 One clock; RESET is synchronous and active-high. Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, clock.
- RESET, in, 1, synchronous active-high reset.
- AVL_CS, in, 1, chip select.
- AVL_READ, in, 1, read strobe.
- AVL_WRITE, in, 1, write strobe.
- AVL_BYTE_EN, in, 4, byte enables.
- AVL_ADDR, in, ADDR_W, word address.
- AVL_WRITEDATA, in, 32, write data.
- AVL_READDATA, out, 32, registered read data.
- AVL_READDATAVALID, out, 1, read data valid.
- CORE_OPERANDS, out, NUM_RW*32, operand words; word 0 occupies the MSBs.
- CORE_START, out, 1, one-cycle start pulse.
- CORE_DONE, in, 1, core completion.
- CORE_RESULT, in, NUM_RO*32, result words; word NUM_RW occupies the MSBs.
- EXPORT_DATA, out, 32, {REG[EXP_HI][31:16], REG[EXP_LO][15:0]}.
REQ-003 CTRL is at address NUM_REGS-2; STATUS is at address NUM_REGS-1; all other addresses are reserved.

Function
REQ-004 A write is AVL_CS & AVL_WRITE sampled at a rising CLK edge; a write updates only the bytes whose AVL_BYTE_EN bit is 1, and the remaining bytes keep their value.
REQ-005 Writes to RO words and to reserved addresses are ignored.
REQ-006 Writes to RW words while the FSM is BUSY are ignored and set STATUS.WR_LOCK (bit 3), which is sticky.
REQ-007 A read is AVL_CS & AVL_READ at edge N.
- AVL_READDATA holds the addressed word during cycle N+1.
- AVL_READDATAVALID is 1 for exactly that cycle.
- Reserved addresses and CTRL read as 0.
- At all other times AVL_READDATA is 0 and AVL_READDATAVALID is 0.
REQ-008 The FSM has the states IDLE, BUSY and DONE.
REQ-009 A write to CTRL with byte 0 enabled and WRITEDATA[0]=1 is a START request.
- In IDLE or DONE: CORE_START=1 for the following cycle only, state goes to BUSY, STATUS.DONE is cleared, and the BUSY counter is cleared.
REQ-010 A START request in BUSY is ignored and sets STATUS.OVERRUN (bit 2), which is sticky.
REQ-011 In BUSY, CORE_DONE=1 at an edge captures CORE_RESULT into the RO words and sets STATUS.DONE (bit 0); state goes to DONE, and the result is readable at the next read.
REQ-012 CORE_DONE is ignored in IDLE and in DONE.
REQ-013 In BUSY the counter increments every cycle; when TIMEOUT is not 0 and the counter reaches TIMEOUT without CORE_DONE, STATUS.TIMEOUT (bit 4) is set, the RO words are unchanged, and state goes to IDLE.
REQ-014 If CORE_DONE arrives in the same cycle the counter reaches TIMEOUT, the result is captured and TIMEOUT is not set.
REQ-015 STATUS bit 1 (BUSY) is 1 exactly while the state is BUSY; bits 31:5 read as 0.
REQ-016 STATUS bits 0, 2, 3 and 4 are write-1-to-clear when byte 0 is enabled; a DONE capture in the same cycle as a DONE clear leaves DONE=1.
REQ-017 A write to STATUS that clears DONE while in DONE moves the FSM to IDLE.
REQ-018 CORE_OPERANDS and EXPORT_DATA are combinational from the registers.

Reset
REQ-019 RESET=1 at an edge, including mid-operation, sets the following, and reset overrides any simultaneous write or CORE_DONE:
- all registers 0;
- FSM IDLE;
- counter 0;
- CORE_START 0;
- AVL_READDATA 0;
- AVL_READDATAVALID 0;
- all STATUS bits 0.

Verification
REQ-020 Byte merge: write word 1 with 0xAABBCCDD, BE=1111, then write 0x11223344 with BE=0101; reading word 1 -> 0xAA22CC44 with READDATAVALID one cycle after the read.
REQ-021 Normal operation: write START at edge N; CORE_DONE at N+5 with result 0x0123...CDEF -> CORE_START high only in cycle N+1, STATUS=0x2 while BUSY, then STATUS=0x1, and RO words match the result.
REQ-022 Protection: write RW word 0 and issue START while BUSY -> word 0 unchanged and STATUS=0x0E; writing STATUS=0x0C -> STATUS=0x2.
REQ-023 Timeout: set TIMEOUT=16 and never assert CORE_DONE -> state returns to IDLE 16 cycles after BUSY is entered, STATUS=0x10, RO words unchanged.
REQ-024 Reset mid-BUSY: assert RESET while BUSY -> next cycle STATUS=0, all words read 0, EXPORT_DATA=0, and a late CORE_DONE is ignored.
